// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall fan-out, exception flush FSM, stall watchdog and stall counter.
// stall_o is combinational in the same cycle; flush_o/new_pc_o/counters are registered one edge later.
module pipe_ctrl #(
  parameter int NUM_STAGES   = 6,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_LIMIT  = 8,
  parameter int CNT_W        = 32,
  parameter int ADDR_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic                  excp_i,
  input  logic [ADDR_W-1:0]     excp_pc_i,
  input  logic                  clear_cnt_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [ADDR_W-1:0]     new_pc_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic                  stall_timeout_o
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] pc_d;
  logic [SC_W-1:0]   scnt_q;
  logic              stall_any;
  logic              acc;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = new_pc_o;
    case (state_q)
      RUN: begin
        if (excp_i) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES);
          pc_d    = excp_pc_i;
        end
      end
      FLUSH: begin
        // Leave on the edge where the remaining count hits zero.
        fcnt_d = fcnt_q - FC_W'(1);
        if (fcnt_q == FC_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A stall at stage r must freeze every older stage j <= r, so OR-down from the top.
  always_comb begin
    stall_o = '0;
    acc     = 1'b0;
    if (rst && (state_q == RUN) && !excp_i) begin
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
        acc        = acc | stallreq_i[j];
        stall_o[j] = acc;
      end
    end
  end

  assign stall_any = |stall_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= RUN;
      fcnt_q          <= '0;
      flush_o         <= 1'b0;
      new_pc_o        <= '0;
      scnt_q          <= '0;
      stall_cycles_o  <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      flush_o  <= (state_d == FLUSH);
      new_pc_o <= pc_d;

      if (stall_any) begin
        if (scnt_q != SC_W'(STALL_LIMIT)) scnt_q <= scnt_q + SC_W'(1);
        if (scnt_q == SC_W'(STALL_LIMIT - 1)) stall_timeout_o <= 1'b1;
      end else begin
        scnt_q <= '0;
      end

      if (clear_cnt_i) begin
        stall_cycles_o <= '0;
      end else if (stall_o[0] && (stall_cycles_o != '1)) begin
        stall_cycles_o <= stall_cycles_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios followed by random traffic against a reference model.
module tb_pipe_ctrl;

  localparam int NS   = 6;
  localparam int FC   = 3;
  localparam int SL   = 8;
  localparam int CW   = 6;
  localparam int AW   = 32;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NS-1:0] stallreq_i = '0;
  logic          excp_i = 1'b0;
  logic [AW-1:0] excp_pc_i = '0;
  logic          clear_cnt_i = 1'b0;
  logic [NS-1:0] stall_o;
  logic          flush_o;
  logic [AW-1:0] new_pc_o;
  logic [CW-1:0] stall_cycles_o;
  logic          stall_timeout_o;

  pipe_ctrl #(
    .NUM_STAGES(NS), .FLUSH_CYCLES(FC), .STALL_LIMIT(SL), .CNT_W(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excp_i(excp_i),
    .excp_pc_i(excp_pc_i), .clear_cnt_i(clear_cnt_i), .stall_o(stall_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_cycles_o(stall_cycles_o),
    .stall_timeout_o(stall_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] stall;
    logic          flush;
    logic [AW-1:0] pc;
    logic [CW-1:0] cyc;
    logic          to;
  } exp_t;

  exp_t exq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state as seen after the most recent edge.
  bit          m_flush = 0;
  int          m_left  = 0;
  logic [31:0] m_pc    = '0;
  int          m_consec = 0;
  bit          m_to    = 0;
  int          m_cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic [NS-1:0] req, input logic ex,
                      input logic [AW-1:0] epc, input logic clr);
    exp_t e;
    int   h;
    @(posedge clk);
    #1;
    rst = r; stallreq_i = req; excp_i = ex; excp_pc_i = epc; clear_cnt_i = clr;

    // Every stage up to the highest requester stalls, unless reset, flush or a new exception.
    e.stall = '0;
    if (r && !m_flush && !ex) begin
      h = -1;
      for (int i = 0; i < NS; i++) if (req[i]) h = i;
      e.stall = NS'((1 << (h + 1)) - 1);
    end
    e.flush = m_flush;
    e.pc    = m_pc;
    e.cyc   = CW'(m_cyc);
    e.to    = m_to;
    exq.push_back(e);

    if (!r) begin
      m_flush = 0; m_left = 0; m_pc = '0; m_consec = 0; m_to = 0; m_cyc = 0;
    end else begin
      if (m_flush) begin
        m_left--;
        if (m_left == 0) m_flush = 0;
      end else if (ex) begin
        m_flush = 1; m_left = FC; m_pc = epc;
      end
      if (e.stall != 0) begin
        m_consec = (m_consec < SL) ? m_consec + 1 : SL;
        if (m_consec == SL) m_to = 1;
      end else begin
        m_consec = 0;
      end
      if (clr) m_cyc = 0;
      else if (e.stall[0] && m_cyc < CMAX) m_cyc++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        check("stall_o", 32'(stall_o), 32'(e.stall));
        check("flush_o", 32'(flush_o), 32'(e.flush));
        check("new_pc_o", new_pc_o, e.pc);
        check("stall_cycles_o", 32'(stall_cycles_o), 32'(e.cyc));
        check("stall_timeout_o", 32'(stall_timeout_o), 32'(e.to));
      end
    end
  end

  initial begin : stimulus
    int t;
    logic [NS-1:0] rq;
    // Reset with requests present: stall_o must stay low.
    step(0, 6'b111111, 0, 0, 0);
    step(0, 6'b000100, 1, 32'h55, 0);
    // Three cycles of an ex-stage stall.
    repeat (3) step(1, 6'b001000, 0, 0, 0);
    step(1, 6'b000000, 0, 0, 0);
    step(1, 6'b000110, 0, 0, 0);
    // Exception while stalling, then drain the flush.
    step(1, 6'b000100, 1, 32'h0000_0020, 0);
    repeat (5) step(1, 6'b000100, 0, 0, 0);
    // Second pulse inside the flush window is ignored.
    step(1, 6'b000000, 1, 32'h0000_0100, 0);
    step(1, 6'b000000, 0, 0, 0);
    step(1, 6'b010000, 1, 32'h0000_0200, 0);
    repeat (4) step(1, 6'b000000, 0, 0, 0);
    // Level exception: accepted again on the first RUN cycle after the flush.
    step(1, 6'b000000, 1, 32'h0000_0300, 0);
    repeat (FC) step(1, 6'b000001, 1, 32'h0000_0400, 0);
    step(1, 6'b000000, 1, 32'h0000_0500, 0);
    repeat (FC + 1) step(1, 6'b000000, 0, 0, 0);
    // Watchdog trip, stickiness, and clear during an active stall.
    repeat (10) step(1, 6'b000001, 0, 0, 0);
    repeat (2) step(1, 6'b000000, 0, 0, 0);
    step(1, 6'b000001, 0, 0, 1);
    step(1, 6'b000000, 0, 0, 0);
    // Long stall to saturate the cycle counter.
    repeat (CMAX + 8) step(1, 6'b100000, 0, 0, 0);
    step(1, 6'b000011, 0, 0, 1);
    step(1, 6'b000000, 0, 0, 0);
    // Reset in the middle of a flush aborts it.
    step(1, 6'b000000, 1, 32'h0000_0040, 0);
    step(1, 6'b000000, 0, 0, 0);
    step(0, 6'b000010, 0, 0, 0);
    repeat (3) step(1, 6'b000000, 0, 0, 0);
    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      case ($urandom_range(0, 3))
        0:       rq = '0;
        1:       rq = NS'(1 << $urandom_range(0, NS - 1));
        default: rq = NS'($urandom);
      endcase
      step(($urandom_range(0, 63) != 0), rq, ($urandom_range(0, 7) == 0),
           $urandom, ($urandom_range(0, 15) == 0));
    end

    t = 0;
    while (exq.size() > 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    #1;
    if (exq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 6, number of pipeline stages (0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb), minimum 2.
REQ-002 Parameter FLUSH_CYCLES, default 1, cycles flush_o is held after an accepted exception, minimum 1.
REQ-003 Parameter STALL_LIMIT, default 8, consecutive-stall count that trips the watchdog, minimum 2.
REQ-004 Parameter CNT_W, default 32, width of the stall performance counter.
REQ-005 Parameter ADDR_W, default 32, width of exception PC.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst  input  1 (reset_status_t)  synchronous, active-low reset, sampled on rising edge of clk.
REQ-008 stallreq_i  input  NUM_STAGES  bit r = stage r requests a stall.
REQ-009 excp_i  input  1  exception/flush request, one-cycle pulse or level.
REQ-010 excp_pc_i  input  ADDR_W  handler PC, valid when excp_i=1.
REQ-011 clear_cnt_i  input  1  synchronous clear of stall_cycles_o.
REQ-012 stall_o  output  NUM_STAGES  bit j = hold stage j.
REQ-013 flush_o  output  1  flush all pipeline registers, redirect fetch.
REQ-014 new_pc_o  output  ADDR_W  redirect target, valid while flush_o=1.
REQ-015 stall_cycles_o  output  CNT_W  saturating count of cycles with stall_o[0]=1.
REQ-016 stall_timeout_o  output  1  sticky watchdog flag.

Function
REQ-017 FSM states RUN and FLUSH; a flush counter holds the remaining flush cycles.
REQ-018 In RUN with no excp_i, stall_o[j] SHALL be 1 iff some r>=j has stallreq_i[r]=1 (combinational, same cycle); e.g. stallreq_i=6'b000100 -> stall_o=6'b000111.
REQ-019 In RUN, excp_i=1 SHALL force stall_o=0 in that cycle, latch excp_pc_i into new_pc_o, load the flush counter with FLUSH_CYCLES, and enter FLUSH on the next edge.
REQ-020 In FLUSH, flush_o SHALL be 1 (registered output), stall_o SHALL be 0, excp_i and stallreq_i SHALL be ignored, and the counter SHALL decrement each cycle.
REQ-021 FLUSH SHALL return to RUN on the edge on which the counter reaches zero; flush_o is therefore high for exactly FLUSH_CYCLES cycles, starting the cycle after excp_i.
REQ-022 new_pc_o SHALL hold its last latched value outside FLUSH.
REQ-023 excp_i asserted on the first RUN cycle after FLUSH SHALL be accepted (back-to-back flushes permitted, one RUN cycle gap).
REQ-024 The consecutive-stall counter SHALL increment each cycle stall_o!=0, reset to 0 on any cycle stall_o=0, and saturate at STALL_LIMIT.
REQ-025 stall_timeout_o SHALL set on the edge at which the counter reaches STALL_LIMIT and remain 1 until reset.
REQ-026 stall_cycles_o SHALL increment by 1 on each cycle with stall_o[0]=1, saturate at all-ones, and clear to 0 when clear_cnt_i=1; clear wins over simultaneous increment.

Reset
REQ-027 While rst is low at a clock edge: state=RUN, flush_o=0, new_pc_o=0, flush counter=0, stall counter=0, stall_cycles_o=0, stall_timeout_o=0.
REQ-028 stall_o SHALL be 0 in any cycle rst is low, regardless of stallreq_i.
REQ-029 Reset asserted during FLUSH SHALL abort the flush: flush_o=0 on the following cycle.

Verification
REQ-030 stallreq_i=6'b001000 for 3 cycles -> stall_o=6'b001111 those cycles, stall_cycles_o=3, stall_timeout_o=0.
REQ-031 stallreq_i=6'b000110 -> stall_o=6'b000111 (highest requester dominates).
REQ-032 excp_i=1, excp_pc_i=32'h0000_0020 while stallreq_i=6'b000100 -> stall_o=0 that cycle; next cycle flush_o=1, new_pc_o=32'h20; following cycle flush_o=0 (FLUSH_CYCLES=1).
REQ-033 FLUSH_CYCLES=3, excp_i pulses twice 2 cycles apart -> flush_o high exactly 3 cycles; second pulse ignored; new_pc_o keeps first value.
REQ-034 stallreq_i=6'b000001 held 10 cycles -> stall_timeout_o rises at 8th edge, stays 1 after stallreq_i drops; clear_cnt_i=1 with stall active -> stall_cycles_o=0 next cycle.
REQ-035 rst low for one edge during FLUSH with FLUSH_CYCLES=3 -> flush_o=0, new_pc_o=0, counters 0 on next cycle.
